// File: rtl/counter_bank_if.sv
// Command/status bundle between requesters and the counter bank scheduler.
// The master side posts commands; the slave side (the scheduler) grants them
// and publishes the counter state.
interface counter_bank_if #(
  parameter int SIZE    = 10,
  parameter int NUM_REQ = 2
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [SIZE*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [SIZE*NUM_REQ-1:0]   cnt;
  logic [NUM_REQ-1:0]        wrap;
  logic [SIZE-1:0]           sum;
  logic                      done_valid;
  logic [IDW-1:0]            done_id;

  modport master (
    output en, req_valid, req_op, req_data,
    input  req_ready, cnt, wrap, sum, done_valid, done_id
  );

  modport slave (
    input  en, req_valid, req_op, req_data,
    output req_ready, cnt, wrap, sum, done_valid, done_id
  );
endinterface

// File: rtl/counter_bank_scheduler.sv
// Round-robin scheduler for a bank of counters sharing one update path.
// One command per cycle is granted (inc/dec/clear/load) to the first valid
// requester at or after the round-robin pointer. A registered modular sum of
// all counters trails the counter registers by one cycle.
module counter_bank_scheduler #(
  parameter int SIZE    = 10,
  parameter int NUM_REQ = 2
) (
  input  logic           clk,
  input  logic           rst,
  counter_bank_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDW-1:0] id_t;

  localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] CNT_MAX = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] CNT_ZERO = {SIZE{1'b0}};

  logic [SIZE-1:0]    cnt_q [NUM_REQ];
  logic [NUM_REQ-1:0] wrap_q;
  logic [SIZE-1:0]    sum_q;
  logic               done_valid_q;
  id_t                done_id_q;
  id_t                rr_ptr_q;

  logic [NUM_REQ-1:0] grant_d;
  logic               grant_any_d;
  id_t                grant_id_d;
  logic [1:0]         grant_op_d;
  logic [SIZE-1:0]    grant_data_d;
  id_t                rr_next_d;
  logic [SIZE-1:0]    sum_d;

  // Index of the k-th candidate after the round-robin pointer, modulo NUM_REQ.
  function automatic id_t rr_index(input id_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return id_t'(s);
  endfunction

  // Pick the first valid requester starting at the pointer; reset and en=0 block grants.
  always_comb begin
    grant_d      = '0;
    grant_any_d  = 1'b0;
    grant_id_d   = '0;
    grant_op_d   = 2'b00;
    grant_data_d = '0;
    if (!rst && bus.en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any_d && bus.req_valid[rr_index(rr_ptr_q, k)]) begin
          grant_any_d  = 1'b1;
          grant_id_d   = rr_index(rr_ptr_q, k);
          grant_d[grant_id_d] = 1'b1;
          grant_op_d   = bus.req_op[2*int'(grant_id_d) +: 2];
          grant_data_d = bus.req_data[SIZE*int'(grant_id_d) +: SIZE];
        end else begin
          grant_any_d  = grant_any_d;
        end
      end
    end else begin
      grant_any_d = 1'b0;
    end
  end

  // Pointer advances to the requester just after the winner.
  always_comb begin
    rr_next_d = '0;
    if (grant_id_d == id_t'(NUM_REQ - 1)) begin
      rr_next_d = '0;
    end else begin
      rr_next_d = grant_id_d + id_t'(1);
    end
  end

  // Modular sum of the current counter registers.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_d = sum_d + cnt_q[i];
    end
  end

  // Apply the granted command; reset discards any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      wrap_q       <= '0;
      sum_q        <= CNT_ZERO;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      sum_q <= sum_d;
      if (grant_any_d) begin
        case (grant_op_d)
          2'b00: begin
            cnt_q[grant_id_d] <= cnt_q[grant_id_d] + CNT_ONE;
            if (cnt_q[grant_id_d] == CNT_MAX) begin
              wrap_q[grant_id_d] <= 1'b1;
            end
          end
          2'b01: begin
            cnt_q[grant_id_d] <= cnt_q[grant_id_d] - CNT_ONE;
            if (cnt_q[grant_id_d] == CNT_ZERO) begin
              wrap_q[grant_id_d] <= 1'b1;
            end
          end
          2'b10: begin
            cnt_q[grant_id_d]  <= CNT_ZERO;
            wrap_q[grant_id_d] <= 1'b0;
          end
          2'b11: begin
            cnt_q[grant_id_d] <= grant_data_d;
          end
          default: begin
            cnt_q[grant_id_d] <= cnt_q[grant_id_d];
          end
        endcase
        rr_ptr_q     <= rr_next_d;
        done_valid_q <= 1'b1;
        done_id_q    <= grant_id_d;
      end else begin
        done_valid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign bus.cnt[g*SIZE +: SIZE] = cnt_q[g];
  end

  assign bus.req_ready  = grant_d;
  assign bus.wrap       = wrap_q;
  assign bus.sum        = sum_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_counter_bank_scheduler.sv
// Bench for counter_bank_scheduler: directed scenarios followed by random
// traffic, checked against an arithmetic reference model and a scoreboard of
// expected completions.
module tb_counter_bank_scheduler;
  localparam int SIZE = 10;
  localparam int N    = 2;
  localparam int MOD  = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_bank_if #(.SIZE(SIZE), .NUM_REQ(N)) bus ();

  counter_bank_scheduler #(.SIZE(SIZE), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int due;
    int id;
    int cnt;
    int wrap;
  } exp_t;

  exp_t sbq[$];

  int cyc   = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst === 1'b1) armed <= 1'b1;

  // Reference model state
  int m_cnt [N];
  int m_wrap[N];
  int m_sum;
  int m_rr;
  int m_g;
  int m_op;
  logic [N-1:0] m_exp_rdy;
  exp_t m_e;

  // Model: check state and ready, then advance as the coming edge will.
  always @(negedge clk) begin
    m_g = -1;
    if (rst === 1'b0 && bus.en === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        if (m_g < 0 && bus.req_valid[(m_rr + k) % N] === 1'b1) m_g = (m_rr + k) % N;
      end
    end
    m_exp_rdy = '0;
    if (m_g >= 0) m_exp_rdy[m_g] = 1'b1;
    if (armed || rst === 1'b1) check("req_ready", 32'(bus.req_ready), 32'(m_exp_rdy));
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cnt%0d", i), 32'(bus.cnt[i*SIZE +: SIZE]), m_cnt[i]);
        check($sformatf("wrap%0d", i), 32'(bus.wrap[i]), m_wrap[i]);
      end
      check("sum", 32'(bus.sum), m_sum);
    end
    if (rst === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i]  = 0;
        m_wrap[i] = 0;
      end
      m_sum = 0;
      m_rr  = 0;
    end else if (armed) begin
      m_sum = 0;
      for (int i = 0; i < N; i++) m_sum = m_sum + m_cnt[i];
      m_sum = m_sum % MOD;
      if (m_g >= 0) begin
        m_op = int'(bus.req_op[2*m_g +: 2]);
        case (m_op)
          0: begin
            if (m_cnt[m_g] == MOD - 1) m_wrap[m_g] = 1;
            m_cnt[m_g] = (m_cnt[m_g] + 1) % MOD;
          end
          1: begin
            if (m_cnt[m_g] == 0) m_wrap[m_g] = 1;
            m_cnt[m_g] = (m_cnt[m_g] + MOD - 1) % MOD;
          end
          2: begin
            m_cnt[m_g]  = 0;
            m_wrap[m_g] = 0;
          end
          default: m_cnt[m_g] = int'(bus.req_data[m_g*SIZE +: SIZE]);
        endcase
        m_e.due  = cyc + 1;
        m_e.id   = m_g;
        m_e.cnt  = m_cnt[m_g];
        m_e.wrap = m_wrap[m_g];
        sbq.push_back(m_e);
        m_rr = (m_g + 1) % N;
      end
    end
  end

  // Monitor: whenever the DUT reports a completion, pop and compare.
  bit   mon_exp;
  exp_t mon_e;
  always @(negedge clk) begin
    if (armed) begin
      mon_exp = (sbq.size() > 0) && (sbq[0].due == cyc);
      check("done_valid", 32'(bus.done_valid), 32'(mon_exp));
      if (mon_exp) begin
        mon_e = sbq.pop_front();
        if (bus.done_valid === 1'b1) begin
          check("done_id", 32'(bus.done_id), mon_e.id);
          check("done_cnt", 32'(bus.cnt[mon_e.id*SIZE +: SIZE]), mon_e.cnt);
          check("done_wrap", 32'(bus.wrap[mon_e.id]), mon_e.wrap);
        end
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) sbq.delete(0);
    end
  end

  task automatic drive(input logic r, input logic e, input logic [1:0] v,
                       input logic [3:0] o, input logic [19:0] d);
    rst           = r;
    bus.en        = e;
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_data  = d;
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] rdy;

  initial begin
    // 1. reset with all requesters valid
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 20'd0);
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 20'd0);
    check("rst_cnt0", 32'(bus.cnt[9:0]), 32'd0);
    check("rst_cnt1", 32'(bus.cnt[19:10]), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);

    // 2. round robin, both incrementing
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'b11, 4'b0000, 20'd0);
    check("rr_cnt0", 32'(bus.cnt[9:0]), 32'd2);
    check("rr_cnt1", 32'(bus.cnt[19:10]), 32'd2);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 20'd0);
    check("rr_sum", 32'(bus.sum), 32'd4);

    // 3. wrap handling on counter 0
    drive(1'b0, 1'b1, 2'b01, 4'b0011, {10'd0, 10'd1023});
    drive(1'b0, 1'b1, 2'b01, 4'b0000, 20'd0);
    check("wrap_inc_cnt", 32'(bus.cnt[9:0]), 32'd0);
    check("wrap_inc_flag", 32'(bus.wrap[0]), 32'd1);
    drive(1'b0, 1'b1, 2'b01, 4'b0001, 20'd0);
    check("wrap_dec_cnt", 32'(bus.cnt[9:0]), 32'd1023);
    check("wrap_dec_flag", 32'(bus.wrap[0]), 32'd1);
    drive(1'b0, 1'b1, 2'b01, 4'b0010, 20'd0);
    check("clear_cnt", 32'(bus.cnt[9:0]), 32'd0);
    check("clear_flag", 32'(bus.wrap[0]), 32'd0);

    // 4. sum overflow
    drive(1'b0, 1'b1, 2'b01, 4'b0011, {10'd0, 10'd1000});
    drive(1'b0, 1'b1, 2'b10, 4'b1100, {10'd100, 10'd0});
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 20'd0);
    check("sum_overflow", 32'(bus.sum), 32'd76);

    // 5. enable gating
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'b01, 4'b0000, 20'd0);
    check("en_hold_cnt0", 32'(bus.cnt[9:0]), 32'd1000);
    drive(1'b0, 1'b1, 2'b01, 4'b0000, 20'd0);
    check("en_done_valid", 32'(bus.done_valid), 32'd1);
    check("en_done_id", 32'(bus.done_id), 32'd0);
    check("en_cnt0", 32'(bus.cnt[9:0]), 32'd1001);

    // 6. reset coinciding with a load
    drive(1'b1, 1'b1, 2'b10, 4'b1100, {10'd55, 10'd0});
    check("midrst_cnt1", 32'(bus.cnt[19:10]), 32'd0);
    check("midrst_done_valid", 32'(bus.done_valid), 32'd0);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 20'd0);

    // Random traffic; requesters hold their command until granted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 99) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] !== 1'b1 || rdy[i] === 1'b1) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          bus.req_op[2*i +: 2] = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0:       bus.req_data[i*SIZE +: SIZE] = 10'd0;
            1:       bus.req_data[i*SIZE +: SIZE] = 10'd1023;
            2:       bus.req_data[i*SIZE +: SIZE] = 10'd1022;
            default: bus.req_data[i*SIZE +: SIZE] = 10'($urandom_range(0, 1023));
          endcase
        end
      end
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b00, 4'b0000, 20'd0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
